// File: rtl/zmem_wb.sv
// zmem_wb: Z80 memory manager with a posted-write buffer.
//
// Maps the 64K Z80 space through NWIN equal page windows. Each window is
// either ROM or DRAM. ROM accesses drive the ROM controls directly. RAM writes
// are posted into a small FIFO so the Z80 does not stall on them. RAM reads
// wait for the FIFO to drain, then issue a read on the arbiter CPU port and
// hold zclk until the byte is captured into a register.
//
// Ports:
//   fclk, rst_n                  system clock, async active-low reset
//   zpos, zneg                   one-fclk strobes at zclk rise / fall
//   cend                         DRAM cycle end strobe
//   za, zd_in, zd_out, zd_ena    Z80 address / data in / registered read data
//   m1_n..wr_n                   Z80 bus controls
//   win_romnram, win_page        per-window ROM flag and page number
//   romrw_en                     allow ROM writes
//   rompg, romoe_n, romwe_n, csrom  ROM page and controls
//   cpu_req..cpu_strobe          DRAM arbiter CPU port
//   cpu_stall                    freeze zclk
//   wb_empty                     posted-write FIFO empty
module zmem_wb #(
  parameter int NWIN     = 4,
  parameter int PAGE_W   = 8,
  parameter int ROMPG_W  = 5,
  parameter int WB_DEPTH = 4,
  localparam int WB      = $clog2(NWIN),
  localparam int AW      = PAGE_W + 15 - WB
) (
  input  logic                     fclk,
  input  logic                     rst_n,
  input  logic                     zpos,
  input  logic                     zneg,
  input  logic                     cend,
  input  logic [15:0]              za,
  input  logic [7:0]               zd_in,
  output logic [7:0]               zd_out,
  output logic                     zd_ena,
  input  logic                     m1_n,
  input  logic                     rfsh_n,
  input  logic                     mreq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic [NWIN-1:0]          win_romnram,
  input  logic [NWIN*PAGE_W-1:0]   win_page,
  input  logic                     romrw_en,
  output logic [ROMPG_W-1:0]       rompg,
  output logic                     romoe_n,
  output logic                     romwe_n,
  output logic                     csrom,
  output logic                     cpu_req,
  output logic                     cpu_rnw,
  output logic [AW-1:0]            cpu_addr,
  output logic [7:0]               cpu_wrdata,
  output logic                     cpu_wrbsel,
  input  logic [15:0]              cpu_rddata,
  input  logic                     cpu_next,
  input  logic                     cpu_strobe,
  output logic                     cpu_stall,
  output logic                     wb_empty
);

  localparam int PW = $clog2(WB_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_WAITWB, R_REQ, R_DATA} rstate_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          bsel;
    logic [7:0]    data;
  } wb_ent_t;

  // Window decode
  logic [WB-1:0]     win;
  logic [PAGE_W-1:0] page;
  logic              romnram;

  always_comb begin
    win     = za[15:16-WB];
    page    = win_page[win*PAGE_W +: PAGE_W];
    romnram = win_romnram[win];
  end

  assign rompg   = page[ROMPG_W-1:0];
  assign csrom   = romnram;
  assign romoe_n = rd_n | mreq_n;
  assign romwe_n = wr_n | mreq_n | ~romrw_en;
  assign zd_ena  = ~mreq_n & ~rd_n & ~romnram;

  // State
  rstate_t         state_q, state_d;
  logic            wr_seen_q, wr_seen_d;
  logic            rd_seen_q, rd_seen_d;
  logic            pend_q, pend_d;
  wb_ent_t         pend_ent_q, pend_ent_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            rd_bsel_q, rd_bsel_d;
  logic [7:0]      zd_out_q, zd_out_d;
  wb_ent_t         fifo_mem [WB_DEPTH];

  logic            ramreq, wr_ev, rd_ev;
  logic            fifo_empty, fifo_full;
  logic            drain, pop, push_valid, push_do;
  wb_ent_t         new_ent, push_ent, head;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    head       = fifo_mem[rd_ptr_q[PW-1:0]];
  end

  always_comb begin
    state_d    = state_q;
    wr_seen_d  = wr_seen_q;
    rd_seen_d  = rd_seen_q;
    pend_d     = pend_q;
    pend_ent_d = pend_ent_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_addr_d  = rd_addr_q;
    rd_bsel_d  = rd_bsel_q;
    zd_out_d   = zd_out_q;

    ramreq = ~mreq_n & ~romnram & rfsh_n;
    wr_ev  = zneg & ramreq & ~wr_n & ~wr_seen_q;
    rd_ev  = zneg & ramreq & ~rd_n & ~rd_seen_q;

    wr_seen_d = mreq_n ? 1'b0 : (wr_seen_q | wr_ev);
    rd_seen_d = mreq_n ? 1'b0 : (rd_seen_q | rd_ev);

    new_ent.addr = {page, za[15-WB:1]};
    new_ent.bsel = za[0];
    new_ent.data = zd_in;

    // Drain only while no read owns the port.
    drain = ~fifo_empty & ((state_q == R_IDLE) | (state_q == R_WAITWB));
    pop   = drain & cend & cpu_next;

    // A write that finds the FIFO full is parked in pend_* and retried each
    // fclk; a pop in the same cycle frees the slot it needs.
    push_valid = wr_ev | pend_q;
    push_ent   = pend_q ? pend_ent_q : new_ent;
    push_do    = push_valid & (~fifo_full | pop);
    pend_d     = push_valid & ~push_do;
    if (pend_d) pend_ent_d = push_ent;

    if (push_do) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + (PW+1)'(1);

    unique case (state_q)
      R_IDLE: begin
        if (rd_ev) begin
          rd_addr_d = new_ent.addr;
          rd_bsel_d = za[0];
          state_d   = (~fifo_empty | push_do) ? R_WAITWB : R_REQ;
        end
      end
      R_WAITWB: begin
        if (fifo_empty) state_d = R_REQ;
      end
      R_REQ: begin
        if (cend & cpu_next) state_d = R_DATA;
      end
      R_DATA: begin
        if (cpu_strobe) begin
          zd_out_d = rd_bsel_q ? cpu_rddata[7:0] : cpu_rddata[15:8];
          state_d  = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase

    cpu_req    = drain | (state_q == R_REQ);
    cpu_rnw    = (state_q == R_REQ);
    cpu_addr   = (state_q == R_REQ) ? rd_addr_q : head.addr;
    cpu_wrdata = head.data;
    cpu_wrbsel = head.bsel;
    cpu_stall  = (wr_ev & fifo_full) | pend_q |
                 (state_q != R_IDLE) | ((state_q == R_IDLE) & rd_ev);
  end

  assign zd_out   = zd_out_q;
  assign wb_empty = fifo_empty;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= R_IDLE;
      wr_seen_q  <= 1'b0;
      rd_seen_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_ent_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_addr_q  <= '0;
      rd_bsel_q  <= 1'b0;
      zd_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_seen_q  <= wr_seen_d;
      rd_seen_q  <= rd_seen_d;
      pend_q     <= pend_d;
      pend_ent_q <= pend_ent_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_addr_q  <= rd_addr_d;
      rd_bsel_q  <= rd_bsel_d;
      zd_out_q   <= zd_out_d;
    end
  end

  // Storage only; validity is tracked by the pointers.
  always_ff @(posedge fclk) begin
    if (push_do) fifo_mem[wr_ptr_q[PW-1:0]] <= push_ent;
  end

  // Opfetch is handled like a plain read and zpos is not needed.
  logic unused_ok;
  assign unused_ok = &{1'b0, m1_n, zpos};

endmodule

// File: tb/tb_zmem_wb.sv
module tb_zmem_wb;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        zpos, zneg, cend;
  logic [15:0] za;
  logic [7:0]  zd_in, zd_out;
  logic        zd_ena;
  logic        m1_n, rfsh_n, mreq_n, rd_n, wr_n;
  logic [3:0]  win_romnram;
  logic [31:0] win_page;
  logic        romrw_en;
  logic [4:0]  rompg;
  logic        romoe_n, romwe_n, csrom;
  logic        cpu_req, cpu_rnw;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wrdata;
  logic        cpu_wrbsel;
  logic [15:0] cpu_rddata;
  logic        cpu_next, cpu_strobe, cpu_stall, wb_empty;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 fclk = ~fclk;

  zmem_wb #(.NWIN(4), .PAGE_W(8), .ROMPG_W(5), .WB_DEPTH(4)) dut (
    .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .cend(cend),
    .za(za), .zd_in(zd_in), .zd_out(zd_out), .zd_ena(zd_ena),
    .m1_n(m1_n), .rfsh_n(rfsh_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .win_romnram(win_romnram), .win_page(win_page), .romrw_en(romrw_en),
    .rompg(rompg), .romoe_n(romoe_n), .romwe_n(romwe_n), .csrom(csrom),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrdata(cpu_wrdata), .cpu_wrbsel(cpu_wrbsel), .cpu_rddata(cpu_rddata),
    .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_stall(cpu_stall),
    .wb_empty(wb_empty)
  );

  typedef struct {
    logic [15:0] za;
    logic        mreq_n, rd_n, wr_n, rfsh_n, romrw_en;
    logic [4:0]  rompg;
    logic        csrom, romoe_n, romwe_n, zd_ena;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  // One Z80 write cycle; returns cpu_stall seen in the event cycle.
  task automatic zwrite(input logic [15:0] a, input logic [7:0] d, output logic st);
    za = a; zd_in = d; mreq_n = 1'b0; wr_n = 1'b0; zneg = 1'b1;
    #1 st = cpu_stall;
    tick();
    zneg = 1'b0;
    tick();
    mreq_n = 1'b1; wr_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    logic [20:0] ea;

    // win0 ROM p11, win1 ROM p0A, win2 RAM p40, win3 RAM p05
    win_romnram = 4'b0011;
    win_page    = {8'h05, 8'h40, 8'h0A, 8'h11};
    rst_n = 1'b0; zpos = 1'b0; zneg = 1'b0; cend = 1'b0;
    za = 16'h0000; zd_in = 8'h00; m1_n = 1'b1; rfsh_n = 1'b1;
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; romrw_en = 1'b0;
    cpu_rddata = 16'h0000; cpu_next = 1'b0; cpu_strobe = 1'b0;

    vecs[0] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'h11, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'h4321, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'h0A, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'h4321, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'h0A, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{16'hC123, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'h05, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'h05, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'h0A, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'hA000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    tick();
    check("rst_zd_out", zd_out, 0);
    check("rst_cpu_req", cpu_req, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_wb_empty", wb_empty, 1);
    rst_n = 1'b1;
    tick();

    // Decode table (no zneg, so no events)
    for (int i = 0; i < 8; i++) begin
      za = vecs[i].za; mreq_n = vecs[i].mreq_n; rd_n = vecs[i].rd_n;
      wr_n = vecs[i].wr_n; rfsh_n = vecs[i].rfsh_n; romrw_en = vecs[i].romrw_en;
      #1;
      check($sformatf("v%0d_rompg", i), rompg, vecs[i].rompg);
      check($sformatf("v%0d_csrom", i), csrom, vecs[i].csrom);
      check($sformatf("v%0d_romoe_n", i), romoe_n, vecs[i].romoe_n);
      check($sformatf("v%0d_romwe_n", i), romwe_n, vecs[i].romwe_n);
      check($sformatf("v%0d_zd_ena", i), zd_ena, vecs[i].zd_ena);
      check($sformatf("v%0d_cpu_req", i), cpu_req, 0);
      tick();
    end
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1; romrw_en = 1'b0;
    tick();

    // Single write to C123, granted at next cend
    cpu_next = 1'b1;
    za = 16'hC123; zd_in = 8'h3C; mreq_n = 1'b0; wr_n = 1'b0; zneg = 1'b1;
    #1 check("w1_stall_evt", cpu_stall, 0);
    tick();
    zneg = 1'b0;
    check("w1_wb_empty", wb_empty, 0);
    check("w1_req", cpu_req, 1);
    check("w1_rnw", cpu_rnw, 0);
    check("w1_addr", cpu_addr, 21'h00A091);
    check("w1_bsel", cpu_wrbsel, 1);
    check("w1_data", cpu_wrdata, 8'h3C);
    mreq_n = 1'b1; wr_n = 1'b1;
    tick();
    check("w1_hold_nocend", wb_empty, 0);
    cend = 1'b1;
    tick();
    cend = 1'b0;
    check("w1_popped", wb_empty, 1);
    check("w1_req_off", cpu_req, 0);

    // Five writes with no grant: 5th stalls until the first pop
    cpu_next = 1'b0;
    for (int k = 0; k < 5; k++) begin
      zwrite(16'h8010 + 16'(k), 8'hA0 + 8'(k), st);
      check($sformatf("b_stall_evt%0d", k), st, (k == 4) ? 1 : 0);
    end
    tick();
    check("b_stall_hold", cpu_stall, 1);
    check("b_head_data0", cpu_wrdata, 8'hA0);
    check("b_head_addr0", cpu_addr, 21'h080008);
    cpu_next = 1'b1; cend = 1'b1;
    tick();
    check("b_stall_drop", cpu_stall, 0);
    for (int k = 1; k < 5; k++) begin
      ea = 21'h080000 | 21'((16 + k) >> 1);
      check($sformatf("b_head_data%0d", k), cpu_wrdata, 8'hA0 + 8'(k));
      check($sformatf("b_head_addr%0d", k), cpu_addr, ea);
      check($sformatf("b_head_bsel%0d", k), cpu_wrbsel, k & 1);
      tick();
    end
    cend = 1'b0;
    check("b_empty", wb_empty, 1);
    check("b_req_off", cpu_req, 0);

    // Write 5A to 8000, then read 8000 while the write is still buffered
    cpu_next = 1'b0;
    zwrite(16'h8000, 8'h5A, st);
    check("c_wr_stall", st, 0);
    za = 16'h8000; mreq_n = 1'b0; rd_n = 1'b0; zneg = 1'b1;
    #1 check("c_rd_stall_evt", cpu_stall, 1);
    tick();
    zneg = 1'b0;
    check("c_waitwb_stall", cpu_stall, 1);
    check("c_waitwb_rnw", cpu_rnw, 0);
    check("c_waitwb_data", cpu_wrdata, 8'h5A);
    check("c_zd_ena", zd_ena, 1);
    cpu_next = 1'b1; cend = 1'b1;
    tick();
    cend = 1'b0;
    tick();
    check("c_req_rnw", cpu_rnw, 1);
    check("c_req", cpu_req, 1);
    check("c_req_addr", cpu_addr, 21'h080000);
    check("c_req_stall", cpu_stall, 1);
    cend = 1'b1;
    tick();
    cend = 1'b0;
    check("c_data_stall", cpu_stall, 1);
    check("c_data_req", cpu_req, 0);
    cpu_rddata = 16'h5A77; cpu_strobe = 1'b1;
    tick();
    cpu_strobe = 1'b0;
    check("c_zd_out", zd_out, 8'h5A);
    check("c_stall_rel", cpu_stall, 0);
    mreq_n = 1'b1; rd_n = 1'b1;
    tick();

    // Odd-address read returns the low byte
    za = 16'hC001; mreq_n = 1'b0; rd_n = 1'b0; zneg = 1'b1;
    tick();
    zneg = 1'b0;
    check("o_req_addr", cpu_addr, 21'h00A000);
    cend = 1'b1;
    tick();
    cend = 1'b0;
    cpu_rddata = 16'h12C7; cpu_strobe = 1'b1;
    tick();
    cpu_strobe = 1'b0;
    check("o_zd_out", zd_out, 8'hC7);
    mreq_n = 1'b1; rd_n = 1'b1;
    tick();

    // ROM write/read and refresh never reach the DRAM port
    romrw_en = 1'b1;
    za = 16'h0010; mreq_n = 1'b0; wr_n = 1'b0; zneg = 1'b1;
    #1 check("r_romwe_n", romwe_n, 0);
    tick();
    zneg = 1'b0;
    check("r_wr_req", cpu_req, 0);
    check("r_wr_empty", wb_empty, 1);
    mreq_n = 1'b1; wr_n = 1'b1; romrw_en = 1'b0;
    tick();
    za = 16'h4010; mreq_n = 1'b0; rd_n = 1'b0; zneg = 1'b1;
    #1 check("r_rd_stall", cpu_stall, 0);
    tick();
    zneg = 1'b0;
    check("r_rd_req", cpu_req, 0);
    mreq_n = 1'b1; rd_n = 1'b1;
    tick();
    za = 16'h8000; mreq_n = 1'b0; rd_n = 1'b0; rfsh_n = 1'b0; zneg = 1'b1;
    #1 check("f_rfsh_stall", cpu_stall, 0);
    tick();
    zneg = 1'b0;
    check("f_rfsh_req", cpu_req, 0);
    mreq_n = 1'b1; rd_n = 1'b1; rfsh_n = 1'b1;
    tick();

    // Reset with buffered writes and a read in flight
    cpu_next = 1'b0;
    for (int k = 0; k < 3; k++) zwrite(16'h8020 + 16'(k), 8'h10 + 8'(k), st);
    za = 16'h8040; mreq_n = 1'b0; rd_n = 1'b0; zneg = 1'b1;
    tick();
    zneg = 1'b0;
    check("x_pre_stall", cpu_stall, 1);
    check("x_pre_empty", wb_empty, 0);
    #2 rst_n = 1'b0;
    #1;
    check("x_wb_empty", wb_empty, 1);
    check("x_cpu_req", cpu_req, 0);
    check("x_cpu_stall", cpu_stall, 0);
    check("x_zd_out", zd_out, 0);
    mreq_n = 1'b1; rd_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("x_post_empty", wb_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
